// File: rtl/uart_fifo_mmio.sv
// uart_fifo_mmio: memory-mapped UART with TX/RX FIFOs, optional parity, 1/2 stop bits and loopback.
module uart_fifo_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          TX_DEPTH    = 16,
    parameter int          RX_DEPTH    = 16,
    parameter logic [15:0] BAUDDIV_RST = 16'd433
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        as_n,
    input  logic        we_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_ONE = 1;
    localparam logic [RAW:0] RX_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [7:0]  tx_mem [TX_DEPTH];
    logic [7:0]  rx_mem [RX_DEPTH];
    logic [TAW:0] tx_wp_q, tx_rp_q;
    logic [RAW:0] rx_wp_q, rx_rp_q, rx_lvl;
    logic [7:0]  ctrl_q;
    logic [15:0] baud_q;
    logic [3:0]  sticky_q;

    logic        sel, wr, rd, ctrl_wr, stat_wr, clr_tx, clr_rx;
    logic [1:0]  ra;
    logic        tx_empty, tx_full, rx_empty, rx_full, tx_idle;
    logic        tx_push, tx_pop, tx_drop, tx_tick, tx_end;
    logic        rx_push, rx_push_ok, rx_pop, rx_drop, rx_tick, rx_perr, rx_ferr, rx_in;
    logic [15:0] rx_half;
    logic [31:0] status;
    logic        unused_bits;

    state_t      tx_st_q, rx_st_q;
    logic [15:0] tx_cnt_q, tx_div_q, rx_cnt_q, rx_div_q;
    logic [2:0]  tx_n_q, rx_n_q;
    logic [7:0]  tx_byte_q, rx_byte_q;
    logic        tx_par_q, tx_odd_q, tx_stop2_q, tx_o_q;
    logic        rx_par_q, rx_odd_q, rx_stop2_q;
    logic [1:0]  rx_sync_q;

    assign sel     = !as_n && addr[31:4] == BASE_ADDR[31:4];
    assign ra      = addr[3:2];
    assign wr      = sel && !we_n;
    assign rd      = sel && we_n;
    assign ctrl_wr = wr && ra == 2'd2;
    assign stat_wr = wr && ra == 2'd1;
    assign clr_rx  = ctrl_wr && wdata[8];
    assign clr_tx  = ctrl_wr && wdata[9];

    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = tx_wp_q[TAW] != tx_rp_q[TAW] && tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0];
    assign rx_empty = rx_wp_q == rx_rp_q;
    assign rx_full  = rx_wp_q[RAW] != rx_rp_q[RAW] && rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0];
    assign rx_lvl   = rx_wp_q - rx_rp_q;
    assign tx_idle  = tx_empty && tx_st_q == S_IDLE;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign tx_tick    = tx_cnt_q == tx_div_q;
    assign tx_end     = tx_st_q == S_STOP && tx_tick && (tx_n_q[0] || !tx_stop2_q);
    assign tx_pop     = ctrl_q[0] && !tx_empty && !clr_tx && (tx_st_q == S_IDLE || tx_end);
    assign tx_push    = wr && ra == 2'd0 && (!tx_full || tx_pop) && !clr_tx;
    assign tx_drop    = wr && ra == 2'd0 && tx_full && !tx_pop && !clr_tx;
    assign rx_pop     = rd && ra == 2'd0 && !rx_empty;
    assign rx_push_ok = rx_push && (!rx_full || rx_pop) && !clr_rx;
    assign rx_drop    = rx_push && rx_full && !rx_pop && !clr_rx;

    assign rx_in   = rx_sync_q[1];
    assign rx_tick = rx_cnt_q == rx_div_q;
    assign rx_half = 16'((17'(rx_div_q) + 17'd1) >> 1);
    assign rx_push = ctrl_q[1] && rx_st_q == S_STOP && rx_tick && (rx_n_q[0] || !rx_stop2_q);
    assign rx_ferr = ctrl_q[1] && rx_st_q == S_STOP && rx_tick && !rx_in;
    assign rx_perr = ctrl_q[1] && rx_st_q == S_PAR && rx_tick && (rx_in != (^rx_byte_q ^ rx_odd_q));

    assign status = {8'h0, 8'(rx_lvl), 7'h0, tx_idle, sticky_q, rx_full, !rx_empty, tx_full, tx_empty};
    assign rdata  = !sel ? 32'h0 :
                    ra == 2'd0 ? (rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp_q[RAW-1:0]]}) :
                    ra == 2'd1 ? status :
                    ra == 2'd2 ? {24'h0, ctrl_q} : {16'h0, baud_q};
    assign irq         = (ctrl_q[6] && !rx_empty) || (ctrl_q[7] && tx_empty);
    assign uart_tx     = tx_o_q;
    assign unused_bits = ^{wdata[31:16], addr[1:0]};

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= wdata[7:0];
        if (rx_push_ok) rx_mem[rx_wp_q[RAW-1:0]] <= rx_byte_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q   <= 8'h03;
            baud_q   <= BAUDDIV_RST;
            sticky_q <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
        end else begin
            if (ctrl_wr) ctrl_q <= wdata[7:0];
            if (wr && ra == 2'd3) baud_q <= wdata[15:0] < 16'd15 ? 16'd15 : wdata[15:0];
            sticky_q <= (sticky_q & ~(stat_wr ? wdata[7:4] : 4'h0)) | {tx_drop, rx_perr, rx_ferr, rx_drop};
            if (clr_tx) begin
                tx_wp_q <= '0;
                tx_rp_q <= '0;
            end else begin
                if (tx_push) tx_wp_q <= tx_wp_q + TX_ONE;
                if (tx_pop) tx_rp_q <= tx_rp_q + TX_ONE;
            end
            if (clr_rx) begin
                rx_wp_q <= '0;
                rx_rp_q <= '0;
            end else begin
                if (rx_push_ok) rx_wp_q <= rx_wp_q + RX_ONE;
                if (rx_pop) rx_rp_q <= rx_rp_q + RX_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_st_q    <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_n_q     <= '0;
            tx_byte_q  <= '0;
            tx_par_q   <= 1'b0;
            tx_odd_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_o_q     <= 1'b1;
        end else if (!ctrl_q[0]) begin
            tx_st_q <= S_IDLE;
            tx_o_q  <= 1'b1;
        end else if (tx_pop) begin
            tx_st_q    <= S_START;
            tx_byte_q  <= tx_mem[tx_rp_q[TAW-1:0]];
            tx_div_q   <= baud_q;
            tx_par_q   <= ctrl_q[3];
            tx_odd_q   <= ctrl_q[4];
            tx_stop2_q <= ctrl_q[5];
            tx_cnt_q   <= '0;
            tx_n_q     <= '0;
            tx_o_q     <= 1'b0;
        end else if (tx_st_q != S_IDLE) begin
            if (!tx_tick) begin
                tx_cnt_q <= tx_cnt_q + 16'd1;
            end else begin
                tx_cnt_q <= '0;
                case (tx_st_q)
                    S_START: begin
                        tx_st_q <= S_DATA;
                        tx_o_q  <= tx_byte_q[0];
                    end
                    S_DATA: begin
                        tx_n_q <= tx_n_q + 3'd1;
                        if (tx_n_q != 3'd7) tx_o_q <= tx_byte_q[tx_n_q + 3'd1];
                        else if (tx_par_q) {tx_st_q, tx_o_q} <= {S_PAR, ^tx_byte_q ^ tx_odd_q};
                        else {tx_st_q, tx_o_q} <= {S_STOP, 1'b1};
                    end
                    S_PAR: {tx_st_q, tx_o_q} <= {S_STOP, 1'b1};
                    default: begin
                        if (tx_end) tx_st_q <= S_IDLE;
                        else tx_n_q <= 3'd1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_sync_q <= 2'b11;
        else rx_sync_q <= {rx_sync_q[0], ctrl_q[2] ? tx_o_q : uart_rx};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_st_q    <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_n_q     <= '0;
            rx_byte_q  <= '0;
            rx_par_q   <= 1'b0;
            rx_odd_q   <= 1'b0;
            rx_stop2_q <= 1'b0;
        end else if (!ctrl_q[1]) begin
            rx_st_q <= S_IDLE;
        end else begin
            case (rx_st_q)
                S_IDLE: if (!rx_in) begin
                    rx_st_q    <= S_START;
                    rx_cnt_q   <= '0;
                    rx_div_q   <= baud_q;
                    rx_par_q   <= ctrl_q[3];
                    rx_odd_q   <= ctrl_q[4];
                    rx_stop2_q <= ctrl_q[5];
                end
                S_START: begin
                    if (rx_cnt_q != rx_half) begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end else begin
                        rx_cnt_q <= '0;
                        rx_n_q   <= '0;
                        rx_st_q  <= rx_in ? S_IDLE : S_DATA;
                    end
                end
                default: begin
                    if (!rx_tick) begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end else begin
                        rx_cnt_q <= '0;
                        case (rx_st_q)
                            S_DATA: begin
                                rx_byte_q <= {rx_in, rx_byte_q[7:1]};
                                rx_n_q    <= rx_n_q + 3'd1;
                                if (rx_n_q == 3'd7) rx_st_q <= rx_par_q ? S_PAR : S_STOP;
                            end
                            S_PAR: rx_st_q <= S_STOP;
                            default: begin
                                if (rx_n_q[0] || !rx_stop2_q) rx_st_q <= S_IDLE;
                                else rx_n_q <= 3'd1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/uart_fifo_mmio.md
UART_FIFO_MMIO -- requirements
Module: uart_fifo_mmio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, 16-byte-aligned decode base.
REQ-002 SHALL have parameter TX_DEPTH, default 16, TX FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter RX_DEPTH, default 16, RX FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter BAUDDIV_RST, default 433, reset value of the BAUD register (50 MHz, 115200).
REQ-005 SHALL have port clk  in  1  clock.
REQ-006 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port as_n  in  1  active-low access strobe. Each clk cycle with as_n low is one access.
REQ-008 SHALL have port we_n  in  1  0=write, 1=read.
REQ-009 SHALL have port addr  in  32  byte address.
REQ-010 SHALL have port wdata  in  32  write data.
REQ-011 SHALL have port rdata  out  32  combinational read data, 0 when not selected.
REQ-012 SHALL have port uart_rx  in  1  serial input, asynchronous.
REQ-013 SHALL have port uart_tx  out  1  serial output, registered, idle high.
REQ-014 SHALL have port irq  out  1  level interrupt.

Function
REQ-015 SHALL select when as_n=0 and addr[31:4]==BASE_ADDR[31:4]. Register map by addr[3:2]: 0 DATA, 1 STATUS, 2 CTRL, 3 BAUD.
REQ-016 SHALL handle DATA writes by pushing wdata[7:0] to the TX FIFO. If the FIFO is full, the byte is dropped and TX_OVF is set (sticky).
REQ-017 SHALL handle DATA reads by returning {24'h0, RX head} and popping. When the RX FIFO is empty, the read returns 0 and no state changes.
REQ-018 SHALL return on STATUS reads: [0] TX_EMPTY, [1] TX_FULL, [2] RX_VALID (not empty), [3] RX_FULL, [4] RX_OVR, [5] FRAME_ERR, [6] PARITY_ERR, [7] TX_OVF, [8] TX_IDLE (FIFO empty and shifter idle), [23:16] RX level. Writing 1 to bits [7:4] clears them (W1C).
REQ-019 SHALL implement CTRL as follows. R/W fields: [0] TX_EN, [1] RX_EN, [2] LOOPBACK, [3] PAR_EN, [4] PAR_ODD, [5] STOP2, [6] IE_RX, [7] IE_TX. Self-clearing write-only fields, read as 0: [8] CLR_RX flushes the RX FIFO; [9] CLR_TX flushes the TX FIFO.
REQ-020 SHALL implement BAUD [15:0] as ticks-per-bit minus 1. Written values below 15 are stored as 15.
REQ-021 SHALL drive irq = (IE_RX & RX_VALID) | (IE_TX & TX_EMPTY).
REQ-022 SHALL use this frame format: start(0), 8 data bits LSB first, parity bit if PAR_EN (even, or odd if PAR_ODD), then 1 stop bit, or 2 if STOP2.
REQ-023 SHALL latch BAUD, PAR_EN, PAR_ODD and STOP2 at frame start in both the TX and RX engines. Mid-frame changes affect only the next frame.
REQ-024 SHALL start TX as follows. When the TX engine is idle, TX_EN=1 and the FIFO is non-empty, it pops one byte, and uart_tx goes low on the next clk edge.
REQ-025 SHALL hold each TX bit for BAUD+1 clk cycles. A queued byte's start bit follows the final stop bit with no idle gap.
REQ-026 SHALL, when TX_EN is cleared, abort any frame in progress, drive uart_tx=1 and keep the FIFO contents.
REQ-027 SHALL pass uart_rx through a 2-flop synchronizer. With LOOPBACK=1, the RX input is uart_tx and uart_tx still drives the pin.
REQ-028 SHALL run the RX FSM with states IDLE, START, DATA, PARITY, STOP, and transitions as follows:
- IDLE to START on input low.
- START checks the input at (BAUD+1)/2 ticks; high returns to IDLE as a glitch.
- DATA samples 8 bits, each BAUD+1 ticks apart.
- PARITY is visited only if PAR_EN; a mismatch sets PARITY_ERR.
- STOP samples 1 or 2 stop bits; a 0 sample sets FRAME_ERR.
- STOP returns to IDLE.
REQ-029 SHALL push the byte at the end of STOP, even if it has an error. If the RX FIFO is full, the byte is dropped and RX_OVR is set.
REQ-030 SHALL, when RX_EN=0, force the RX FSM to IDLE and keep the FIFO.
REQ-031 SHALL let a pop and a push in the same cycle both take effect, leaving the level unchanged. This applies to either FIFO, including the full case: pop first, then push succeeds.
REQ-032 SHALL let FIFO pointers wrap modulo depth, with full and empty distinguished by an extra pointer bit.
REQ-033 SHALL make CLR_RX/CLR_TX take priority over a push or pop in the same cycle.

Reset
REQ-034 SHALL, on reset_n low, immediately and asynchronously set: uart_tx=1, irq=0, both FIFOs empty, all sticky flags 0, TX_EN=1, RX_EN=1, other CTRL bits 0, BAUD=BAUDDIV_RST, both FSMs idle.
REQ-035 SHALL abort any frame in progress on reset with no partial byte pushed, and resume normal operation on the first clk edge after reset_n rises.

Verification
REQ-036 SHALL verify: BAUD=15; write 0x55 to DATA -> start bit for 16 clk, data bits 1,0,1,0,1,0,1,0, one stop bit; TX_IDLE=1 after 160 clk.
REQ-037 SHALL verify: LOOPBACK=1, PAR_EN=1, PAR_ODD=1, STOP2=1; write 0xA3, 0x00, 0xFF -> three DATA reads return them in order; PARITY_ERR=0; FRAME_ERR=0.
REQ-038 SHALL verify: TX_EN=0; write TX_DEPTH+1 bytes -> TX_FULL=1 and TX_OVF=1; set TX_EN=1 -> exactly TX_DEPTH frames sent back to back.
REQ-039 SHALL verify: inject RX_DEPTH+1 frames without reading -> RX level=RX_DEPTH, RX_OVR=1; first read returns the first byte; writing STATUS 0x10 clears RX_OVR.
REQ-040 SHALL verify: inject a frame with stop bit 0 -> byte pushed, FRAME_ERR=1; inject a 0.3-bit low glitch -> nothing pushed.
REQ-041 SHALL verify: assert reset_n mid-TX-frame -> uart_tx=1 in the same cycle, FIFOs empty, BAUD=433 after release.
